// File: rtl/alu_dispatch_pkg.sv
// Shared opcode/funct/rt encodings and E-stage ALU control constants.
// Also holds the mul/div classification helpers used by the dispatch FSM.
package alu_dispatch_pkg;

   localparam int OP_W = 8;
   typedef logic [OP_W-1:0] op_t;

   // Primary opcode field
   localparam logic [5:0] EXE_NOP         = 6'b000000;
   localparam logic [5:0] EXE_REGIMM_INST = 6'b000001;
   localparam logic [5:0] EXE_J           = 6'b000010;
   localparam logic [5:0] EXE_JAL         = 6'b000011;
   localparam logic [5:0] EXE_BEQ         = 6'b000100;
   localparam logic [5:0] EXE_BNE         = 6'b000101;
   localparam logic [5:0] EXE_ADDI        = 6'b001000;
   localparam logic [5:0] EXE_ADDIU       = 6'b001001;
   localparam logic [5:0] EXE_SLTI        = 6'b001010;
   localparam logic [5:0] EXE_ANDI        = 6'b001100;
   localparam logic [5:0] EXE_ORI         = 6'b001101;
   localparam logic [5:0] EXE_XORI        = 6'b001110;
   localparam logic [5:0] EXE_LUI         = 6'b001111;
   localparam logic [5:0] EXE_LW          = 6'b100011;
   localparam logic [5:0] EXE_SW          = 6'b101011;

   // R-type funct field
   localparam logic [5:0] EXE_SLL   = 6'b000000;
   localparam logic [5:0] EXE_SRL   = 6'b000010;
   localparam logic [5:0] EXE_SRA   = 6'b000011;
   localparam logic [5:0] EXE_JR    = 6'b001000;
   localparam logic [5:0] EXE_MFHI  = 6'b010000;
   localparam logic [5:0] EXE_MFLO  = 6'b010010;
   localparam logic [5:0] EXE_MULT  = 6'b011000;
   localparam logic [5:0] EXE_MULTU = 6'b011001;
   localparam logic [5:0] EXE_DIV   = 6'b011010;
   localparam logic [5:0] EXE_DIVU  = 6'b011011;
   localparam logic [5:0] EXE_ADD   = 6'b100000;
   localparam logic [5:0] EXE_ADDU  = 6'b100001;
   localparam logic [5:0] EXE_SUB   = 6'b100010;
   localparam logic [5:0] EXE_SUBU  = 6'b100011;
   localparam logic [5:0] EXE_AND   = 6'b100100;
   localparam logic [5:0] EXE_OR    = 6'b100101;
   localparam logic [5:0] EXE_XOR   = 6'b100110;
   localparam logic [5:0] EXE_NOR   = 6'b100111;
   localparam logic [5:0] EXE_SLT   = 6'b101010;
   localparam logic [5:0] EXE_SLTU  = 6'b101011;

   // REGIMM rt field
   localparam logic [4:0] EXE_BLTZ   = 5'b00000;
   localparam logic [4:0] EXE_BGEZ   = 5'b00001;
   localparam logic [4:0] EXE_BLTZAL = 5'b10000;
   localparam logic [4:0] EXE_BGEZAL = 5'b10001;

   // ALU control encodings
   localparam op_t EXE_NOP_OP    = 8'h00;
   localparam op_t EXE_SLL_OP    = 8'h01;
   localparam op_t EXE_SRL_OP    = 8'h02;
   localparam op_t EXE_SRA_OP    = 8'h03;
   localparam op_t EXE_JR_OP     = 8'h04;
   localparam op_t EXE_MFHI_OP   = 8'h05;
   localparam op_t EXE_MFLO_OP   = 8'h06;
   localparam op_t EXE_MULT_OP   = 8'h07;
   localparam op_t EXE_MULTU_OP  = 8'h08;
   localparam op_t EXE_DIV_OP    = 8'h09;
   localparam op_t EXE_DIVU_OP   = 8'h0A;
   localparam op_t EXE_ADD_OP    = 8'h0B;
   localparam op_t EXE_ADDU_OP   = 8'h0C;
   localparam op_t EXE_SUB_OP    = 8'h0D;
   localparam op_t EXE_SUBU_OP   = 8'h0E;
   localparam op_t EXE_AND_OP    = 8'h0F;
   localparam op_t EXE_OR_OP     = 8'h10;
   localparam op_t EXE_XOR_OP    = 8'h11;
   localparam op_t EXE_NOR_OP    = 8'h12;
   localparam op_t EXE_SLT_OP    = 8'h13;
   localparam op_t EXE_SLTU_OP   = 8'h14;
   localparam op_t EXE_J_OP      = 8'h15;
   localparam op_t EXE_JAL_OP    = 8'h16;
   localparam op_t EXE_BEQ_OP    = 8'h17;
   localparam op_t EXE_BNE_OP    = 8'h18;
   localparam op_t EXE_ADDI_OP   = 8'h19;
   localparam op_t EXE_ADDIU_OP  = 8'h1A;
   localparam op_t EXE_SLTI_OP   = 8'h1B;
   localparam op_t EXE_ANDI_OP   = 8'h1C;
   localparam op_t EXE_ORI_OP    = 8'h1D;
   localparam op_t EXE_XORI_OP   = 8'h1E;
   localparam op_t EXE_LUI_OP    = 8'h1F;
   localparam op_t EXE_LW_OP     = 8'h20;
   localparam op_t EXE_SW_OP     = 8'h21;
   localparam op_t EXE_BLTZ_OP   = 8'h22;
   localparam op_t EXE_BGEZ_OP   = 8'h23;
   localparam op_t EXE_BLTZAL_OP = 8'h24;
   localparam op_t EXE_BGEZAL_OP = 8'h25;

   function automatic logic is_div(input op_t op);
      return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
   endfunction

   function automatic logic is_mul(input op_t op);
      return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP);
   endfunction

endpackage

// File: rtl/alu_dispatch_opdecode.sv
// Combinational instruction decode: opcode/funct/rt -> ALU control plus
// an unsupported-encoding flag.
module alu_opdecode
   import alu_dispatch_pkg::*;
(
   input  logic [5:0] aluop,
   input  logic [5:0] funct,
   input  logic [4:0] rt,
   output op_t        ctrl,
   output logic       ri
);

   always_comb begin
      // NOTE: defaults before the case keep every path assigned, so no latch is inferred.
      ctrl = EXE_NOP_OP;
      ri   = 1'b0;
      unique case (aluop)
         EXE_NOP: begin
            unique case (funct)
               EXE_SLL:   ctrl = EXE_SLL_OP;
               EXE_SRL:   ctrl = EXE_SRL_OP;
               EXE_SRA:   ctrl = EXE_SRA_OP;
               EXE_JR:    ctrl = EXE_JR_OP;
               EXE_MFHI:  ctrl = EXE_MFHI_OP;
               EXE_MFLO:  ctrl = EXE_MFLO_OP;
               EXE_MULT:  ctrl = EXE_MULT_OP;
               EXE_MULTU: ctrl = EXE_MULTU_OP;
               EXE_DIV:   ctrl = EXE_DIV_OP;
               EXE_DIVU:  ctrl = EXE_DIVU_OP;
               EXE_ADD:   ctrl = EXE_ADD_OP;
               EXE_ADDU:  ctrl = EXE_ADDU_OP;
               EXE_SUB:   ctrl = EXE_SUB_OP;
               EXE_SUBU:  ctrl = EXE_SUBU_OP;
               EXE_AND:   ctrl = EXE_AND_OP;
               EXE_OR:    ctrl = EXE_OR_OP;
               EXE_XOR:   ctrl = EXE_XOR_OP;
               EXE_NOR:   ctrl = EXE_NOR_OP;
               EXE_SLT:   ctrl = EXE_SLT_OP;
               EXE_SLTU:  ctrl = EXE_SLTU_OP;
               default:   ri   = 1'b1;
            endcase
         end
         EXE_REGIMM_INST: begin
            unique case (rt)
               EXE_BLTZ:   ctrl = EXE_BLTZ_OP;
               EXE_BGEZ:   ctrl = EXE_BGEZ_OP;
               EXE_BLTZAL: ctrl = EXE_BLTZAL_OP;
               EXE_BGEZAL: ctrl = EXE_BGEZAL_OP;
               default:    ri   = 1'b1;
            endcase
         end
         EXE_J:     ctrl = EXE_J_OP;
         EXE_JAL:   ctrl = EXE_JAL_OP;
         EXE_BEQ:   ctrl = EXE_BEQ_OP;
         EXE_BNE:   ctrl = EXE_BNE_OP;
         EXE_ADDI:  ctrl = EXE_ADDI_OP;
         EXE_ADDIU: ctrl = EXE_ADDIU_OP;
         EXE_SLTI:  ctrl = EXE_SLTI_OP;
         EXE_ANDI:  ctrl = EXE_ANDI_OP;
         EXE_ORI:   ctrl = EXE_ORI_OP;
         EXE_XORI:  ctrl = EXE_XORI_OP;
         EXE_LUI:   ctrl = EXE_LUI_OP;
         EXE_LW:    ctrl = EXE_LW_OP;
         EXE_SW:    ctrl = EXE_SW_OP;
         default:   ri   = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_dispatch.sv
// E-stage dispatch register with a mul/div occupancy FSM that stalls the
// front end while a multi-cycle operation executes.
module alu_dispatch
   import alu_dispatch_pkg::*;
#(
   parameter int CTRL_W     = 8,
   parameter int DIV_CYCLES = 32,
   parameter int MUL_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        aluop,
   input  logic [5:0]        funct,
   input  logic [4:0]        rt,
   input  logic              in_valid,
   input  logic              stall_in,
   input  logic              flush,
   output logic [CTRL_W-1:0] alucontrol_e,
   output logic              valid_e,
   output logic              ri_e,
   output logic              stall_out,
   output logic              md_done
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);
   localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 1);

   state_t     state;
   logic [7:0] cnt;
   op_t        dec_ctrl;
   logic       dec_ri;
   logic       hold;
   logic       start_md;
   logic [7:0] md_load;

   alu_opdecode u_opdecode (
      .aluop (aluop),
      .funct (funct),
      .rt    (rt),
      .ctrl  (dec_ctrl),
      .ri    (dec_ri)
   );

   assign stall_out = (state == BUSY) && (cnt != 8'd0);
   assign md_done   = (state == BUSY) && (cnt == 8'd0);
   assign hold      = stall_in || stall_out;
   // Flush is excluded here by the priority order in the register block.
   assign start_md  = !hold && in_valid && (is_div(dec_ctrl) || is_mul(dec_ctrl));
   assign md_load   = is_div(dec_ctrl) ? DIV_LOAD : MUL_LOAD;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         alucontrol_e <= CTRL_W'(EXE_NOP_OP);
         valid_e      <= 1'b0;
         ri_e         <= 1'b0;
         state        <= IDLE;
         cnt          <= 8'd0;
      end else begin
         if (!hold) begin
            alucontrol_e <= CTRL_W'(dec_ctrl);
            valid_e      <= in_valid;
            ri_e         <= in_valid && dec_ri;
         end
         unique case (state)
            IDLE: begin
               if (start_md) begin
                  state <= BUSY;
                  cnt   <= md_load;
               end
            end
            BUSY: begin
               if (cnt != 8'd0) begin
                  cnt <= cnt - 8'd1;
               end else if (start_md) begin
                  cnt <= md_load;
               end else if (!hold) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= 8'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_dispatch.sv
// Scoreboard bench for alu_dispatch: table-driven decode model plus a
// remaining-cycles occupancy model, checked every cycle by a monitor.
module tb_alu_dispatch;
   import alu_dispatch_pkg::*;

   localparam int DIV_N = 32;
   localparam int MUL_N = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] aluop = '0;
   logic [5:0] funct = '0;
   logic [4:0] rt = '0;
   logic       in_valid = 1'b0;
   logic       stall_in = 1'b0;
   logic       flush = 1'b0;
   logic [7:0] alucontrol_e;
   logic       valid_e, ri_e, stall_out, md_done;

   always #5 clk = ~clk;

   alu_dispatch #(.CTRL_W(8), .DIV_CYCLES(DIV_N), .MUL_CYCLES(MUL_N)) dut (
      .clk(clk), .rst(rst), .aluop(aluop), .funct(funct), .rt(rt),
      .in_valid(in_valid), .stall_in(stall_in), .flush(flush),
      .alucontrol_e(alucontrol_e), .valid_e(valid_e), .ri_e(ri_e),
      .stall_out(stall_out), .md_done(md_done)
   );

   typedef struct {
      logic [7:0] ctrl;
      logic       valid;
      logic       ri;
      logic       stall;
      logic       done;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cycle = 0;

   // Reference decode tables and legal-key lists for stimulus.
   logic [7:0] r_map[logic [5:0]];
   logic [7:0] i_map[logic [5:0]];
   logic [7:0] b_map[logic [4:0]];
   logic [5:0] r_keys[$];
   logic [5:0] i_keys[$];

   // Reference E-slot contents and cycles of mul/div execution still owed.
   logic [7:0] m_ctrl = 8'h00;
   bit         m_valid = 0;
   bit         m_ri = 0;
   int         m_left = 0;

   task automatic add_r(input logic [5:0] f, input logic [7:0] op);
      r_map[f] = op;
      r_keys.push_back(f);
   endtask

   task automatic add_i(input logic [5:0] a, input logic [7:0] op);
      i_map[a] = op;
      i_keys.push_back(a);
   endtask

   function automatic void ref_decode(input logic [5:0] a, input logic [5:0] f,
                                      input logic [4:0] r,
                                      output logic [7:0] c, output bit bad);
      c = EXE_NOP_OP;
      bad = 1;
      if (a == EXE_NOP) begin
         if (r_map.exists(f)) begin c = r_map[f]; bad = 0; end
      end else if (a == EXE_REGIMM_INST) begin
         if (b_map.exists(r)) begin c = b_map[r]; bad = 0; end
      end else if (i_map.exists(a)) begin
         c = i_map[a]; bad = 0;
      end
   endfunction

   function automatic int op_cycles(input logic [7:0] c);
      if (c == EXE_DIV_OP || c == EXE_DIVU_OP) return DIV_N;
      if (c == EXE_MULT_OP || c == EXE_MULTU_OP) return MUL_N;
      return 0;
   endfunction

   // One clock of stimulus; the model advances on the same edge and the
   // resulting expected outputs are queued for the monitor.
   task automatic step(input logic [5:0] a, input logic [5:0] f, input logic [4:0] r,
                       input bit v, input bit si, input bit fl, input bit rs);
      logic [7:0] c;
      bit         bad;
      bit         held;
      exp_t       e;
      @(negedge clk);
      #1;
      aluop = a; funct = f; rt = r;
      in_valid = v; stall_in = si; flush = fl; rst = rs;
      ref_decode(a, f, r, c, bad);
      held = si || (m_left > 1);
      @(posedge clk);
      if (rs || fl) begin
         m_ctrl = EXE_NOP_OP; m_valid = 0; m_ri = 0; m_left = 0;
      end else if (held) begin
         if (m_left > 1) m_left--;
      end else begin
         m_ctrl = c; m_valid = v; m_ri = v && bad;
         m_left = v ? op_cycles(c) : 0;
      end
      e.ctrl = m_ctrl; e.valid = m_valid; e.ri = m_ri;
      e.stall = (m_left > 1); e.done = (m_left == 1);
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n, input bit si);
      for (int i = 0; i < n; i++) step(EXE_NOP, EXE_ADD, 5'd0, 1'b0, si, 1'b0, 1'b0);
   endtask

   task automatic rop(input logic [5:0] f);
      step(EXE_NOP, f, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   always @(negedge clk) begin
      cycle++;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         vectors++;
         if (alucontrol_e !== e.ctrl || valid_e !== e.valid || ri_e !== e.ri ||
             stall_out !== e.stall || md_done !== e.done) begin
            miscompares++;
            $display("FAIL e_stage cycle %0d: got ctrl=%h valid=%b ri=%b stall=%b done=%b, want ctrl=%h valid=%b ri=%b stall=%b done=%b",
                     cycle, alucontrol_e, valid_e, ri_e, stall_out, md_done,
                     e.ctrl, e.valid, e.ri, e.stall, e.done);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      add_r(EXE_SLL, EXE_SLL_OP);     add_r(EXE_SRL, EXE_SRL_OP);
      add_r(EXE_SRA, EXE_SRA_OP);     add_r(EXE_JR, EXE_JR_OP);
      add_r(EXE_MFHI, EXE_MFHI_OP);   add_r(EXE_MFLO, EXE_MFLO_OP);
      add_r(EXE_MULT, EXE_MULT_OP);   add_r(EXE_MULTU, EXE_MULTU_OP);
      add_r(EXE_DIV, EXE_DIV_OP);     add_r(EXE_DIVU, EXE_DIVU_OP);
      add_r(EXE_ADD, EXE_ADD_OP);     add_r(EXE_ADDU, EXE_ADDU_OP);
      add_r(EXE_SUB, EXE_SUB_OP);     add_r(EXE_SUBU, EXE_SUBU_OP);
      add_r(EXE_AND, EXE_AND_OP);     add_r(EXE_OR, EXE_OR_OP);
      add_r(EXE_XOR, EXE_XOR_OP);     add_r(EXE_NOR, EXE_NOR_OP);
      add_r(EXE_SLT, EXE_SLT_OP);     add_r(EXE_SLTU, EXE_SLTU_OP);
      add_i(EXE_J, EXE_J_OP);         add_i(EXE_JAL, EXE_JAL_OP);
      add_i(EXE_BEQ, EXE_BEQ_OP);     add_i(EXE_BNE, EXE_BNE_OP);
      add_i(EXE_ADDI, EXE_ADDI_OP);   add_i(EXE_ADDIU, EXE_ADDIU_OP);
      add_i(EXE_SLTI, EXE_SLTI_OP);   add_i(EXE_ANDI, EXE_ANDI_OP);
      add_i(EXE_ORI, EXE_ORI_OP);     add_i(EXE_XORI, EXE_XORI_OP);
      add_i(EXE_LUI, EXE_LUI_OP);     add_i(EXE_LW, EXE_LW_OP);
      add_i(EXE_SW, EXE_SW_OP);
      b_map[EXE_BLTZ] = EXE_BLTZ_OP;     b_map[EXE_BGEZ] = EXE_BGEZ_OP;
      b_map[EXE_BLTZAL] = EXE_BLTZAL_OP; b_map[EXE_BGEZAL] = EXE_BGEZAL_OP;

      // Reset state
      step(EXE_NOP, EXE_ADD, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      step(EXE_NOP, EXE_ADD, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      // R-type ADD
      rop(EXE_ADD);
      idle(2, 1'b0);
      // DIV full latency, with upstream presenting ADD throughout
      rop(EXE_DIV);
      for (int i = 0; i < 34; i++) rop(EXE_ADD);
      // REGIMM legal and reserved rt
      step(EXE_REGIMM_INST, 6'd0, 5'b10001, 1'b1, 1'b0, 1'b0, 1'b0);
      step(EXE_REGIMM_INST, 6'd0, 5'b11111, 1'b1, 1'b0, 1'b0, 1'b0);
      step(6'b111111, 6'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(1, 1'b0);
      // DIV aborted by flush at cycle 10
      rop(EXE_DIV);
      idle(9, 1'b0);
      step(EXE_NOP, EXE_ADD, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(3, 1'b0);
      // Flush colliding with a new DIV: flush wins
      step(EXE_NOP, EXE_DIV, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      idle(2, 1'b0);
      // Back-to-back single-cycle MULT
      rop(EXE_MULT); rop(EXE_MULTU); rop(EXE_MULT);
      idle(2, 1'b0);
      // stall_in holding md_done at the final DIV cycle
      rop(EXE_DIVU);
      idle(31, 1'b0);
      idle(3, 1'b1);
      idle(2, 1'b0);
      // Reset at cycle 5 of a DIV with stall_in asserted
      rop(EXE_DIV);
      idle(4, 1'b1);
      step(EXE_NOP, EXE_ADD, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
      idle(2, 1'b0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         logic [5:0] a, f;
         logic [4:0] r;
         int         k;
         k = $urandom_range(0, 9);
         a = 6'($urandom);
         f = 6'($urandom);
         r = 5'($urandom);
         if (k <= 3) begin
            a = EXE_NOP;
            f = r_keys[$urandom_range(0, r_keys.size() - 1)];
         end else if (k == 4) begin
            a = EXE_NOP;
            f = ($urandom_range(0, 1) == 0) ? EXE_DIV : EXE_MULTU;
         end else if (k == 5) begin
            a = EXE_REGIMM_INST;
         end else if (k <= 7) begin
            a = i_keys[$urandom_range(0, i_keys.size() - 1)];
         end
         step(a, f, r, $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);
      end
      idle(1, 1'b0);

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected vectors left unchecked, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_dispatch.md
ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 Parameter: CTRL_W, 8, width of alucontrol encoding.
REQ-002 Parameter: DIV_CYCLES, 32, execute cycles for DIV/DIVU (legal range 1..255).
REQ-003 Parameter: MUL_CYCLES, 1, execute cycles for MULT/MULTU (legal range 1..255).
REQ-004 Port: clk  in  1  single clock, all state updates on rising edge.
REQ-005 Port: rst  in  1  synchronous, active-high reset.
REQ-006 Port: aluop  in  6  opcode field of decode-stage instruction.
REQ-007 Port: funct  in  6  funct field, used when aluop = EXE_NOP (R-type).
REQ-008 Port: rt  in  5  rt field, used when aluop = EXE_REGIMM_INST.
REQ-009 Port: in_valid  in  1  decode-stage instruction valid.
REQ-010 Port: stall_in  in  1  hazard unit requests hold of the E-stage register.
REQ-011 Port: flush  in  1  squash the E-stage slot and abort any mul/div in progress.
REQ-012 Port: alucontrol_e  out  CTRL_W  registered E-stage ALU control.
REQ-013 Port: valid_e  out  1  E-stage slot holds a valid instruction.
REQ-014 Port: ri_e  out  1  registered reserved-instruction flag (valid but undecodable).
REQ-015 Port: stall_out  out  1  multi-cycle op occupying E; upstream must hold.
REQ-016 Port: md_done  out  1  single-cycle pulse: last execute cycle of a mul/div.

Function
REQ-017 Decode SHALL be combinational: R-type by funct, REGIMM by rt (BGEZ/BLTZ/BLTZAL/BGEZAL), all other supported opcodes by aluop, mapping to the shared *_OP constants.
REQ-018 Unsupported aluop, funct or rt SHALL decode to EXE_NOP_OP; ri flag = in_valid and unsupported.
REQ-019 E-register priority per edge: rst, then flush (alucontrol_e=EXE_NOP_OP, valid_e=0, ri_e=0), then hold if stall_in or stall_out, else capture decode, in_valid, ri flag.
REQ-020 An op is "accepted" on an edge where the E-register captures with in_valid=1.
REQ-021 FSM states IDLE, BUSY; counter cnt is 8 bits.
REQ-022 IDLE->BUSY on acceptance of DIV/DIVU (cnt=DIV_CYCLES-1) or MULT/MULTU (cnt=MUL_CYCLES-1); other ops stay IDLE.
REQ-023 BUSY: cnt decrements each edge while cnt!=0; at cnt==0 the next edge returns to IDLE, or re-enters BUSY if a new mul/div is accepted that same edge.
REQ-024 stall_out = BUSY and cnt!=0 (combinational); md_done = BUSY and cnt==0 (combinational), independent of stall_in.
REQ-025 Latency: op accepted at edge k SHALL assert stall_out for N-1 cycles and md_done in the Nth cycle after k (N = DIV_CYCLES or MUL_CYCLES); N=1 gives no stall.
REQ-026 If stall_in holds at cnt==0, state SHALL stay BUSY with md_done held high until the E-register advances; md_done counts once per op.
REQ-027 flush in any state SHALL force IDLE, cnt=0, no md_done on the following cycles.
REQ-028 Simultaneous flush and in_valid mul/div: flush wins; op not accepted.

Reset
REQ-029 On rst: alucontrol_e=EXE_NOP_OP, valid_e=0, ri_e=0, state=IDLE, cnt=0; hence stall_out=0, md_done=0.
REQ-030 rst mid-BUSY SHALL abort immediately with identical result to REQ-029.

Structure
REQ-031 Opcode, funct, rt and *_OP constants SHALL come from the shared defines header; FSM state encodings SHALL be local.
REQ-032 Combinational decode SHALL be one sub-module, alu_opdecode (inputs aluop/funct/rt, outputs ctrl and ri), instantiated once.

Verification
REQ-033 R-type ADD (aluop=000000, funct=100000, in_valid=1) -> next cycle alucontrol_e=EXE_ADD_OP, valid_e=1, stall_out=0.
REQ-034 DIV (funct=011010), DIV_CYCLES=32 -> stall_out high 31 cycles, md_done high exactly cycle 32, E-register held throughout.
REQ-035 REGIMM aluop=000001, rt=10001 -> EXE_BGEZAL_OP; rt=11111 -> EXE_NOP_OP with ri_e=1.
REQ-036 DIV accepted, flush at cycle 10 -> next cycle IDLE, valid_e=0, stall_out=0, no md_done.
REQ-037 MULT with MUL_CYCLES=1 back-to-back three times -> no stall_out, md_done high three consecutive cycles.
REQ-038 rst asserted at cycle 5 of DIV with stall_in=1 -> all outputs at reset values next cycle.
